// File: rtl/anton_neopixel_apb_bridge.sv
// anton_neopixel_apb_bridge
// Splits each 32-bit APB access into byte-wide accesses on the neopixel register bus.
// Writes issue one busWrite cycle per enabled strobe lane, in ascending lane order.
// Reads issue four busRead cycles and gather the registered responses into apbPrdata.
// Every output comes straight from a flop.
//
// Ports:
//   busClk, busRstN      clock, asynchronous active-low reset
//   apbPsel .. apbPstrb  APB completer request (apbPaddr[1:0] ignored)
//   apbPrdata            read word, held until the next read overwrites it
//   apbPready            one-cycle completion pulse
//   apbPslverr           error response (tied 0 unless ANTON_APB_PSLVERR_EN is defined)
//   busAddr/busDataIn    byte-bus address and write data, held between accesses
//   busWrite/busRead     byte-bus strobes, never high together
//   busDataOut           byte-bus read data, valid the cycle after busRead
//
// Optional feature: define ANTON_APB_PSLVERR_EN so that accesses with apbPaddr[15:14] != 0
// complete at once with apbPslverr set. Without it those address bits are ignored.
module anton_neopixel_apb_bridge (
  input  logic        busClk,
  input  logic        busRstN,
  input  logic        apbPsel,
  input  logic        apbPenable,
  input  logic        apbPwrite,
  input  logic [15:0] apbPaddr,
  input  logic [31:0] apbPwdata,
  input  logic [3:0]  apbPstrb,
  output logic [31:0] apbPrdata,
  output logic        apbPready,
  output logic        apbPslverr,
  output logic [13:0] busAddr,
  output logic [7:0]  busDataIn,
  output logic        busWrite,
  output logic        busRead,
  input  logic [7:0]  busDataOut
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDone} state_e;

  state_e      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  rem_q, rem_d;    // strobe lanes still waiting to be written
  logic [2:0]  cnt_q, cnt_d;    // read step counter, 0..4

  logic [31:0] prdata_d;
  logic        pready_d, pslverr_d;
  logic [13:0] bus_addr_d;
  logic [7:0]  bus_data_in_d;
  logic        bus_write_d, bus_read_d;

  logic        accept, bad_addr, wr_more;
  logic [1:0]  first_lane, next_lane;
  logic [2:0]  cnt_inc, cnt_dec;

  function automatic logic [1:0] low_lane(input logic [3:0] s);
    if (s[0])      return 2'd0;
    else if (s[1]) return 2'd1;
    else if (s[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign accept     = (state_q == StIdle) && apbPsel && apbPenable;
  assign wr_more    = |rem_q;
  assign first_lane = low_lane(apbPstrb);
  assign next_lane  = low_lane(rem_q);
  assign cnt_inc    = cnt_q + 3'd1;
  assign cnt_dec    = cnt_q - 3'd1;

`ifdef ANTON_APB_PSLVERR_EN
  logic pslverr_q;
  logic unused_bits;
  assign bad_addr    = |apbPaddr[15:14];
  assign apbPslverr  = pslverr_q;
  assign unused_bits = ^apbPaddr[1:0];
`else
  logic unused_bits;
  assign bad_addr    = 1'b0;
  assign apbPslverr  = 1'b0;
  assign unused_bits = ^{apbPaddr[15:14], apbPaddr[1:0], pslverr_d};
`endif

  // State and output registers
  always_ff @(posedge busClk or negedge busRstN) begin
    if (!busRstN) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      apbPrdata <= '0;
      apbPready <= 1'b0;
      busAddr   <= '0;
      busDataIn <= '0;
      busWrite  <= 1'b0;
      busRead   <= 1'b0;
`ifdef ANTON_APB_PSLVERR_EN
      pslverr_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      apbPrdata <= prdata_d;
      apbPready <= pready_d;
      busAddr   <= bus_addr_d;
      busDataIn <= bus_data_in_d;
      busWrite  <= bus_write_d;
      busRead   <= bus_read_d;
`ifdef ANTON_APB_PSLVERR_EN
      pslverr_q <= pslverr_d;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          addr_d  = apbPaddr[13:2];
          wdata_d = apbPwdata;
          cnt_d   = 3'd0;
          if (bad_addr) begin
            state_d = StDone;
          end else if (apbPwrite) begin
            // The lowest lane goes out with the accept, so drop it from the remainder
            rem_d   = apbPstrb & (apbPstrb - 4'd1);
            state_d = (|apbPstrb) ? StWrite : StDone;
          end else begin
            state_d = StRead;
          end
        end
      end
      StWrite: begin
        if (wr_more) rem_d = rem_q & (rem_q - 4'd1);
        else         state_d = StDone;
      end
      StRead: begin
        cnt_d = cnt_inc;
        if (cnt_q == 3'd4) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    prdata_d      = apbPrdata;
    pready_d      = 1'b0;
    pslverr_d     = 1'b0;
    bus_addr_d    = busAddr;
    bus_data_in_d = busDataIn;
    bus_write_d   = 1'b0;
    bus_read_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bad_addr) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
          end else if (apbPwrite) begin
            if (|apbPstrb) begin
              bus_write_d   = 1'b1;
              bus_addr_d    = {apbPaddr[13:2], first_lane};
              bus_data_in_d = apbPwdata[{first_lane, 3'b000} +: 8];
            end else begin
              pready_d = 1'b1;
            end
          end else begin
            bus_read_d = 1'b1;
            bus_addr_d = {apbPaddr[13:2], 2'd0};
          end
        end
      end
      StWrite: begin
        if (wr_more) begin
          bus_write_d   = 1'b1;
          bus_addr_d    = {addr_q, next_lane};
          bus_data_in_d = wdata_q[{next_lane, 3'b000} +: 8];
        end else begin
          pready_d = 1'b1;
        end
      end
      StRead: begin
        // Issue of lane cnt+1 overlaps capture of lane cnt-1
        if (cnt_q < 3'd3) begin
          bus_read_d = 1'b1;
          bus_addr_d = {addr_q, cnt_inc[1:0]};
        end
        if (cnt_q != 3'd0) prdata_d[{cnt_dec[1:0], 3'b000} +: 8] = busDataOut;
        if (cnt_q == 3'd4) pready_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_anton_neopixel_apb_bridge.sv
module tb_anton_neopixel_apb_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [13:0] bus_addr;
  logic [7:0]  bus_data_in;
  logic        bus_write, bus_read;
  logic [7:0]  bus_data_out;

  int total = 0;
  int bad = 0;

  logic [7:0]  resp_mem [0:16383];  // responder storage, written by the DUT
  logic [7:0]  ref_mem  [0:16383];  // expected contents, maintained by the bench
  logic [31:0] last_prdata;

  always #5 clk = ~clk;

  anton_neopixel_apb_bridge dut (
    .busClk     (clk),
    .busRstN    (rst_n),
    .apbPsel    (psel),
    .apbPenable (penable),
    .apbPwrite  (pwrite),
    .apbPaddr   (paddr),
    .apbPwdata  (pwdata),
    .apbPstrb   (pstrb),
    .apbPrdata  (prdata),
    .apbPready  (pready),
    .apbPslverr (pslverr),
    .busAddr    (bus_addr),
    .busDataIn  (bus_data_in),
    .busWrite   (bus_write),
    .busRead    (bus_read),
    .busDataOut (bus_data_out)
  );

  // Byte-bus responder with registered read data
  always @(posedge clk) begin
    if (bus_write) resp_mem[bus_addr] <= bus_data_in;
    if (bus_read)  bus_data_out <= resp_mem[bus_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                      input logic [3:0] strb, input logic hold_sel);
    int          wcyc[$];
    logic [13:0] waddr[$];
    logic [7:0]  wdat[$];
    int          rcyc[$];
    logic [13:0] raddr[$];
    int          rdy_cyc;
    logic [31:0] rdy_data;
    logic        rdy_err;
    logic        err;
    int          n;
    int          idx;
    logic [1:0]  kk;
    logic [13:0] ea;
    logic [31:0] exp_rd;
`ifdef ANTON_APB_PSLVERR_EN
    err = (addr[15:14] != 2'b00);
`else
    err = 1'b0;
`endif
    @(posedge clk) #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata; pstrb = strb;
    @(posedge clk) #1;
    penable = 1'b1;
    rdy_cyc = -1; rdy_data = '0; rdy_err = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus_write) begin
        wcyc.push_back(c); waddr.push_back(bus_addr); wdat.push_back(bus_data_in);
      end
      if (bus_read) begin
        rcyc.push_back(c); raddr.push_back(bus_addr);
      end
      check("no_wr_rd_overlap", {31'd0, bus_write & bus_read}, 32'd0);
      if (pready) begin
        rdy_cyc = c; rdy_data = prdata; rdy_err = pslverr;
        break;
      end
    end
    // penable stays high through the completion edge
    @(posedge clk) #1;
    penable = 1'b0; psel = hold_sel;
    @(negedge clk);
    check("post_idle", {29'd0, pready, bus_write, bus_read}, 32'd0);

    check("ready_seen", {31'd0, rdy_cyc >= 0}, 32'd1);
    check("slverr", {31'd0, rdy_err}, {31'd0, err});
    if (err) begin
      check("err_writes", wcyc.size(), 0);
      check("err_reads", rcyc.size(), 0);
      check("err_ready_cycle", rdy_cyc, 1);
      check("err_prdata_held", rdy_data, last_prdata);
    end else if (wr) begin
      n = 0;
      for (int k = 0; k < 4; k++) if (strb[k]) n++;
      check("wr_count", wcyc.size(), n);
      check("wr_no_reads", rcyc.size(), 0);
      idx = 0;
      for (int k = 0; k < 4; k++) begin
        if (strb[k]) begin
          kk = k[1:0];
          ea = {addr[13:2], kk};
          if (idx < wcyc.size()) begin
            check("wr_cycle", wcyc[idx], idx + 1);
            check("wr_addr", waddr[idx], ea);
            check("wr_data", wdat[idx], wdata[8*k +: 8]);
          end
          ref_mem[ea] = wdata[8*k +: 8];
          idx++;
        end
      end
      check("wr_ready_cycle", rdy_cyc, n + 1);
      check("wr_prdata_held", rdy_data, last_prdata);
    end else begin
      check("rd_count", rcyc.size(), 4);
      check("rd_no_writes", wcyc.size(), 0);
      for (int k = 0; k < 4; k++) begin
        kk = k[1:0];
        ea = {addr[13:2], kk};
        exp_rd[8*k +: 8] = ref_mem[ea];
        if (k < rcyc.size()) begin
          check("rd_cycle", rcyc[k], k + 1);
          check("rd_addr", raddr[k], ea);
        end
      end
      check("rd_ready_cycle", rdy_cyc, 6);
      check("rd_data", rdy_data, exp_rd);
      last_prdata = exp_rd;
    end
  endtask

  initial begin
    logic ok;
    for (int i = 0; i < 16384; i++) begin
      resp_mem[i] = 8'($urandom);
      ref_mem[i]  = resp_mem[i];
    end
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    last_prdata = '0;
    #1;
    check("rst_prdata", prdata, 32'd0);
    check("rst_ready", {31'd0, pready}, 32'd0);
    check("rst_slverr", {31'd0, pslverr}, 32'd0);
    check("rst_bus_addr", {18'd0, bus_addr}, 32'd0);
    check("rst_bus_data", {24'd0, bus_data_in}, 32'd0);
    check("rst_strobes", {30'd0, bus_write, bus_read}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed transfers
    xfer(1'b1, 16'h2000, 32'h0000_1234, 4'hF, 1'b0);
    xfer(1'b1, 16'h0010, 32'hAABB_CCDD, 4'b1010, 1'b0);
    xfer(1'b1, 16'h0020, 32'h5566_7788, 4'h0, 1'b0);
    resp_mem[14'h0040] = 8'h11; resp_mem[14'h0041] = 8'h22;
    resp_mem[14'h0042] = 8'h33; resp_mem[14'h0043] = 8'h44;
    ref_mem[14'h0040]  = 8'h11; ref_mem[14'h0041]  = 8'h22;
    ref_mem[14'h0042]  = 8'h33; ref_mem[14'h0043]  = 8'h44;
    xfer(1'b0, 16'h0040, 32'h0, 4'h0, 1'b0);
    check("rd_known_word", last_prdata, 32'h4433_2211);

    // Back-to-back with psel held between transfers
    xfer(1'b1, 16'h0080, 32'hCAFE_F00D, 4'hF, 1'b1);
    xfer(1'b0, 16'h0080, 32'h0, 4'h0, 1'b1);
    xfer(1'b1, 16'h0084, 32'h0102_0304, 4'b0101, 1'b0);

    // Upper address bits: error response or alias depending on build
    xfer(1'b1, 16'h4000, 32'h9988_7766, 4'hF, 1'b0);
    xfer(1'b0, 16'h0000, 32'h0, 4'h0, 1'b0);

    // Reset in cycle 2 of a four-lane write
    @(posedge clk) #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0100;
    pwdata = 32'hDEAD_BEEF; pstrb = 4'hF;
    @(posedge clk) #1;
    penable = 1'b1;
    @(negedge clk);  // cycle 0
    @(negedge clk);  // cycle 1
    @(negedge clk);  // cycle 2
    check("rst_mid_pre", {31'd0, bus_write}, 32'd1);
    #1;
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
    #1;
    check("rst_mid_write", {31'd0, bus_write}, 32'd0);
    check("rst_mid_ready", {31'd0, pready}, 32'd0);
    check("rst_mid_addr", {18'd0, bus_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_mem[14'h0100] = 8'hEF;  // lane 0 landed before the reset
    last_prdata = '0;
    ok = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus_write || bus_read || pready) ok = 1'b0;
    end
    check("rst_mid_quiet", {31'd0, ok}, 32'd1);
    xfer(1'b0, 16'h0100, 32'h0, 4'h0, 1'b0);
    xfer(1'b1, 16'h0104, 32'h1357_9BDF, 4'hF, 1'b0);

    // Randomized transfers against the reference memory
    for (int t = 0; t < 40; t++) begin
      xfer(1'($urandom), 16'($urandom), $urandom, 4'($urandom), 1'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
